muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
Iterative RV64M multiply/divide unit with its own sequencing FSM. It sits beside the execute-stage ALU and takes the same forwarded operands (after the forwarding muxes). It holds the pipeline through a stall request to the hazard unit until its result is ready. It delivers one 64-bit result to the EX/MEM path on a single-cycle done pulse.

Parameters:
XLEN, 64, datapath width; only 64 is supported.
CNT_W, 7, iteration counter width; must hold XLEN.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
MD_Start_E  in  1  M-extension instruction present in EX (decoded op 0110011/0111011 with funct7=0000001).
funct3_E  in  3  M operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
is_word_E  in  1  W-form (op 0111011); only MUL, DIV, DIVU, REM, REMU are legal.
SrcA_E  in  64  forwarded rs1.
SrcB_E  in  64  forwarded rs2.
Flush_E  in  1  kill the EX instruction (branch redirect).
Stall_MD  out  1  to hazard unit; freezes IF/ID/EX while high.
MDDone_E  out  1  result valid this cycle.
MDResult_E  out  64  result; muxed over ALUResult_E when MDDone_E=1.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, counter=0, all internal registers=0; Stall_MD=0, MDDone_E=0, MDResult_E=0.
- States: IDLE, CALC, FIX, DONE.
- IDLE, when MD_Start_E=1 and Flush_E=0:
  - latch operand magnitudes, result-sign flags and op;
  - W-form uses the low 32 bits, sign- or zero-extended per op;
  - counter = 32 (W-form) or 64; go to CALC.
  - Special cases go straight to DONE with the result computed immediately:
    - divide by zero: quotient = all ones, remainder = dividend;
    - signed overflow (most-negative / -1, at 32 or 64 bits): quotient = dividend, remainder = 0.
- CALC:
  - multiply: one shift-add step per cycle into a 128-bit accumulator;
  - divide: one restoring step per cycle; partial remainder and quotient registered;
  - decrement counter; at counter=1, go to FIX.
- FIX: apply the negation from the sign flags (MULH/MULHSU/DIV/REM); select the low/high product half or the quotient/remainder; W-form sign-extends bit 31 into 63:32. Go to DONE.
- DONE: MDDone_E=1, MDResult_E valid for this cycle only. Next state is IDLE unconditionally.
- Stall_MD = MD_Start_E & ~Flush_E & (state != DONE). The signal is combinational, so stall is high in the accept cycle.
- Latency from the accept cycle (cycle 0):
  - 64-bit ops: MDDone_E at cycle 66;
  - W-form: cycle 34;
  - special cases: cycle 1.
  - The EX instruction advances on the DONE edge.
- Back-to-back ops: the next op is accepted in the IDLE cycle after DONE. There is no bubble beyond that cycle.
- Flush_E=1 in any state: next state is IDLE; MDDone_E is suppressed this cycle; Stall_MD=0.
- MD_Start_E dropping in CALC/FIX (not expected): abort to IDLE next cycle; no done pulse.
- rst_n asserted mid-operation: immediate return to reset values; no done pulse after release.
- MDResult_E holds its last value outside DONE; it is only meaningful when MDDone_E=1.

Decomposition:
- Package muldiv_pkg holds:
  - the state enum md_state_t (IDLE/CALC/FIX/DONE);
  - funct3 localparams F3_MUL…F3_REMU;
  - opcode constants OP_OP=0110011 and OP_OP32=0111011;
  - FUNCT7_MULDIV=0000001.
- One sub-module is natural: muldiv_fixup, a combinational block covering sign correction, half/quotient/remainder selection and W-form extension. The FSM, counter and datapath registers stay in muldiv_sequencer.

Test Plan:
- MUL, A=7, B=-3 (0xFFFF_FFFF_FFFF_FFFD) -> Stall_MD high cycles 0–65; MDDone_E at cycle 66; result 0xFFFF_FFFF_FFFF_FFEB.
- MULHU, A=B=0xFFFF_FFFF_FFFF_FFFF -> 0xFFFF_FFFF_FFFF_FFFE. MULH with the same operands -> 0.
- DIV -7/2 -> 0xFFFF_FFFF_FFFF_FFFD. REM -7/2 -> 0xFFFF_FFFF_FFFF_FFFF. DIVW A=0x1_0000_0010, B=4 -> 4 at cycle 34.
- DIVU x/0 -> all ones at cycle 1. REM 0x8000_0000_0000_0000 / -1 -> 0. DIV with the same operands -> 0x8000_0000_0000_0000 at cycle 1.
- Flush_E at cycle 10 of a DIV -> Stall_MD=0 that cycle; no MDDone_E; a new MUL accepted at cycle 11 completes correctly.
- rst_n low at cycle 20 of a MUL, then released -> all outputs 0; state IDLE; no done pulse; the next op completes with correct latency.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV64M multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } md_state_t;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [6:0] OP_OP         = 7'b0110011;
  localparam logic [6:0] OP_OP32       = 7'b0111011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  function automatic logic [63:0] sext32(input logic [31:0] x);
    return {{32{x[31]}}, x};
  endfunction

endpackage

// File: rtl/muldiv_fixup.sv
// Final result shaping: sign correction, product-half / quotient / remainder
// selection and W-form sign extension.
module muldiv_fixup
  import muldiv_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [2:0]        funct3,
  input  logic              is_word,
  input  logic              neg_res,
  input  logic [2*XLEN-1:0] prod,
  input  logic [XLEN-1:0]   quo,
  input  logic [XLEN-1:0]   rem,
  output logic [XLEN-1:0]   result
);

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   sel;

  always_comb begin
    prod_fix = neg_res ? $unsigned(-$signed(prod)) : prod;
    quo_fix  = neg_res ? $unsigned(-$signed(quo))  : quo;
    rem_fix  = neg_res ? $unsigned(-$signed(rem))  : rem;
    sel      = prod_fix[XLEN-1:0];
    case (funct3)
      F3_MUL:                       sel = prod_fix[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: sel = prod_fix[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:              sel = quo_fix;
      F3_REM, F3_REMU:              sel = rem_fix;
      default:                      sel = prod_fix[XLEN-1:0];
    endcase
    result = is_word ? sext32(sel[31:0]) : sel;
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative RV64M multiply/divide unit: shift-add multiply, restoring divide,
// one bit per cycle, with its own IDLE/CALC/FIX/DONE sequencer.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int CNT_W = 7
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            MD_Start_E,
  input  logic [2:0]      funct3_E,
  input  logic            is_word_E,
  input  logic [XLEN-1:0] SrcA_E,
  input  logic [XLEN-1:0] SrcB_E,
  input  logic            Flush_E,
  output logic            Stall_MD,
  output logic            MDDone_E,
  output logic [XLEN-1:0] MDResult_E
);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(XLEN);
  localparam logic [CNT_W-1:0] CNT_WORD = CNT_W'(32);
  localparam logic [XLEN-1:0]  MIN_FULL = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0]  MIN_WORD = sext32(32'h8000_0000);

  md_state_t         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [2:0]        f3_q;
  logic              word_q;
  logic              neg_q;
  logic [2*XLEN-1:0] acc_q;
  logic [2*XLEN-1:0] mcand_q;
  logic [XLEN-1:0]   mplier_q;
  logic [XLEN-1:0]   rem_q;
  logic [XLEN-1:0]   quo_q;
  logic [XLEN-1:0]   dvsr_q;
  logic [XLEN-1:0]   result_q;

  logic                   sgn_a, sgn_b;
  logic signed [XLEN-1:0] a_ext, b_ext;
  logic                   a_neg, b_neg;
  logic [XLEN-1:0]        mag_a, mag_b;
  logic [XLEN-1:0]        op_a, op_b;
  logic                   b_zero, ovf, special;
  logic [XLEN-1:0]        spec_raw, spec_res;
  logic                   neg_in;
  logic                   accept;

  logic [XLEN:0]   div_shift;
  logic            div_ge;
  logic [XLEN-1:0] rem_step;
  logic [XLEN-1:0] fix_res;

  // Operand conditioning for the accept cycle: extension, magnitudes, special cases.
  always_comb begin
    sgn_a = 1'b0;
    sgn_b = 1'b0;
    case (funct3_E)
      F3_MULH, F3_DIV, F3_REM: begin
        sgn_a = 1'b1;
        sgn_b = 1'b1;
      end
      F3_MULHSU: sgn_a = 1'b1;
      default: ;
    endcase

    if (is_word_E) begin
      a_ext = sgn_a ? sext32(SrcA_E[31:0]) : {{(XLEN-32){1'b0}}, SrcA_E[31:0]};
      b_ext = sgn_b ? sext32(SrcB_E[31:0]) : {{(XLEN-32){1'b0}}, SrcB_E[31:0]};
    end else begin
      a_ext = SrcA_E;
      b_ext = SrcB_E;
    end

    a_neg = sgn_a & a_ext[XLEN-1];
    b_neg = sgn_b & b_ext[XLEN-1];
    mag_a = a_neg ? $unsigned(-a_ext) : $unsigned(a_ext);
    mag_b = b_neg ? $unsigned(-b_ext) : $unsigned(b_ext);
    op_a  = is_word_E ? {{(XLEN-32){1'b0}}, mag_a[31:0]} : mag_a;
    op_b  = is_word_E ? {{(XLEN-32){1'b0}}, mag_b[31:0]} : mag_b;

    // Remainder takes the dividend's sign; everything else the product of signs.
    neg_in = (funct3_E[2] & funct3_E[1]) ? a_neg : (a_neg ^ b_neg);

    b_zero  = (b_ext == '0);
    ovf     = ~funct3_E[0] & (a_ext == (is_word_E ? MIN_WORD : MIN_FULL)) & (b_ext == '1);
    special = funct3_E[2] & (b_zero | ovf);

    if (b_zero) spec_raw = funct3_E[1] ? $unsigned(a_ext) : '1;
    else        spec_raw = funct3_E[1] ? '0 : $unsigned(a_ext);
    spec_res = is_word_E ? sext32(spec_raw[31:0]) : spec_raw;
  end

  assign accept = (state_q == IDLE) & MD_Start_E & ~Flush_E;

  // Restoring divide step: shift one dividend bit into the partial remainder.
  always_comb begin
    div_shift = {rem_q, quo_q[XLEN-1]};
    div_ge    = (div_shift >= {1'b0, dvsr_q});
    rem_step  = div_ge ? XLEN'(div_shift - {1'b0, dvsr_q}) : div_shift[XLEN-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    Stall_MD = MD_Start_E & ~Flush_E & (state_q != DONE);
    MDDone_E = (state_q == DONE) & ~Flush_E;
    if (Flush_E) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (MD_Start_E) state_d = special ? DONE : CALC;
        CALC: begin
          if (!MD_Start_E)                  state_d = IDLE;
          else if (cnt_q == CNT_W'(1))      state_d = FIX;
        end
        FIX:     state_d = MD_Start_E ? DONE : IDLE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath registers: load on accept, iterate in CALC, capture result into DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      f3_q     <= '0;
      word_q   <= 1'b0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      result_q <= '0;
    end else if (accept) begin
      cnt_q    <= is_word_E ? CNT_WORD : CNT_FULL;
      f3_q     <= funct3_E;
      word_q   <= is_word_E;
      neg_q    <= neg_in;
      acc_q    <= '0;
      mcand_q  <= {{XLEN{1'b0}}, op_a};
      mplier_q <= op_b;
      rem_q    <= '0;
      quo_q    <= is_word_E ? {op_a[31:0], {(XLEN-32){1'b0}}} : op_a;
      dvsr_q   <= op_b;
      if (special) result_q <= spec_res;
    end else if (state_q == CALC) begin
      cnt_q <= cnt_q - CNT_W'(1);
      if (f3_q[2]) begin
        rem_q <= rem_step;
        quo_q <= {quo_q[XLEN-2:0], div_ge};
      end else begin
        if (mplier_q[0]) acc_q <= acc_q + mcand_q;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
      end
    end else if ((state_q == FIX) && (state_d == DONE)) begin
      result_q <= fix_res;
    end
  end

  muldiv_fixup #(
    .XLEN(XLEN)
  ) u_fixup (
    .funct3  (f3_q),
    .is_word (word_q),
    .neg_res (neg_q),
    .prod    (acc_q),
    .quo     (quo_q),
    .rem     (rem_q),
    .result  (fix_res)
  );

  assign MDResult_E = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: directed vector table, flush/abort/reset
// sequences, and randomized ops against an arithmetic reference model.
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        MD_Start_E = 1'b0;
  logic [2:0]  funct3_E = '0;
  logic        is_word_E = 1'b0;
  logic [63:0] SrcA_E = '0;
  logic [63:0] SrcB_E = '0;
  logic        Flush_E = 1'b0;
  logic        Stall_MD;
  logic        MDDone_E;
  logic [63:0] MDResult_E;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  muldiv_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .MD_Start_E (MD_Start_E),
    .funct3_E   (funct3_E),
    .is_word_E  (is_word_E),
    .SrcA_E     (SrcA_E),
    .SrcB_E     (SrcB_E),
    .Flush_E    (Flush_E),
    .Stall_MD   (Stall_MD),
    .MDDone_E   (MDDone_E),
    .MDResult_E (MDResult_E)
  );

  typedef struct {
    string       name;
    logic [2:0]  f3;
    logic        w;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] res;
    int          lat;
  } vec_t;

  localparam int NVEC = 13;
  vec_t vecs [NVEC];

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: RV64M semantics written directly with SystemVerilog arithmetic.
  function automatic logic [63:0] ref_md(input logic [2:0] f3, input logic w,
                                         input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] sp;
    logic [127:0]        up;
    logic signed [63:0]  sa, sb;
    logic signed [31:0]  sa32, sb32;
    logic [31:0]         ua32, ub32, r32;
    logic [63:0]         r;
    sa = a; sb = b; sa32 = a[31:0]; sb32 = b[31:0]; ua32 = a[31:0]; ub32 = b[31:0];
    r = '0; r32 = '0;
    if (w) begin
      case (f3)
        F3_DIV: begin
          if (ub32 == 0) r32 = '1;
          else if (sa32 == 32'sh8000_0000 && sb32 == -1) r32 = ua32;
          else r32 = sa32 / sb32;
        end
        F3_DIVU: begin
          if (ub32 == 0) r32 = '1;
          else r32 = ua32 / ub32;
        end
        F3_REM: begin
          if (ub32 == 0) r32 = ua32;
          else if (sa32 == 32'sh8000_0000 && sb32 == -1) r32 = '0;
          else r32 = sa32 % sb32;
        end
        F3_REMU: begin
          if (ub32 == 0) r32 = ua32;
          else r32 = ua32 % ub32;
        end
        default: r32 = ua32 * ub32;
      endcase
      return {{32{r32[31]}}, r32};
    end
    case (f3)
      F3_MUL:    begin up = a * b; r = up[63:0]; end
      F3_MULH:   begin sp = sa * sb; r = sp[127:64]; end
      F3_MULHSU: begin sp = sa * $signed({1'b0, b}); r = sp[127:64]; end
      F3_MULHU:  begin up = a * b; r = up[127:64]; end
      F3_DIV: begin
        if (b == 0) r = '1;
        else if (sa == 64'sh8000_0000_0000_0000 && sb == -1) r = a;
        else r = sa / sb;
      end
      F3_DIVU: begin
        if (b == 0) r = '1;
        else r = a / b;
      end
      F3_REM: begin
        if (b == 0) r = a;
        else if (sa == 64'sh8000_0000_0000_0000 && sb == -1) r = '0;
        else r = sa % sb;
      end
      default: begin
        if (b == 0) r = a;
        else r = a % b;
      end
    endcase
    return r;
  endfunction

  function automatic int ref_lat(input logic [2:0] f3, input logic w,
                                 input logic [63:0] a, input logic [63:0] b);
    logic dz, ov;
    dz = w ? (b[31:0] == 32'd0) : (b == 64'd0);
    ov = w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
           : (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF);
    if (f3[2] && (dz || (!f3[0] && ov))) return 1;
    return w ? 34 : 66;
  endfunction

  function automatic logic [63:0] rand_operand();
    logic [63:0] v;
    case ($urandom_range(0, 7))
      0: v = 64'd0;
      1: v = '1;
      2: v = 64'h8000_0000_0000_0000;
      3: v = {$urandom, 32'h8000_0000};
      4: v = 64'($urandom_range(0, 20));
      5: v = -64'($urandom_range(1, 20));
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  // Call at a negedge; drives the op, measures latency, leaves start low one cycle after done.
  task automatic run_op(input string name, input logic [2:0] f3, input logic w,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] res, input int lat);
    int          c;
    bit          done_seen;
    bit          stall_ok;
    logic [63:0] got;
    MD_Start_E = 1'b1; funct3_E = f3; is_word_E = w; SrcA_E = a; SrcB_E = b; Flush_E = 1'b0;
    c = 0; done_seen = 0; stall_ok = 1; got = '0;
    while (!done_seen && c < 200) begin
      #1;
      if (MDDone_E) begin
        done_seen = 1;
        got = MDResult_E;
        if (Stall_MD) stall_ok = 0;
      end else begin
        if (!Stall_MD) stall_ok = 0;
        @(negedge clk);
        c++;
      end
    end
    checks++;
    if (!done_seen || c != lat) begin
      failures++;
      $display("FAIL %s_latency actual=%0d required=%0d done_seen=%0d", name, c, lat, done_seen);
    end
    check64({name, "_result"}, got, res);
    checks++;
    if (!stall_ok) begin
      failures++;
      $display("FAIL %s_stall actual=stall_wrong required=stall_until_done", name);
    end
    @(negedge clk);
    MD_Start_E = 1'b0;
  endtask

  task automatic watch_no_done(input string name, input int ncyc);
    bit seen;
    seen = 0;
    for (int i = 0; i < ncyc; i++) begin
      #1;
      if (MDDone_E) seen = 1;
      @(negedge clk);
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL %s actual=done_pulse required=no_done_pulse", name);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    logic [2:0] w_ops [0:4];
    logic [2:0] f3;
    logic       w;
    logic [63:0] a, b;

    w_ops = '{F3_MUL, F3_DIV, F3_DIVU, F3_REM, F3_REMU};

    vecs[0]  = '{"mul_7_m3",     F3_MUL,    1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 66};
    vecs[1]  = '{"mulhu_ones",   F3_MULHU,  1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 66};
    vecs[2]  = '{"mulh_ones",    F3_MULH,   1'b0, '1, '1, 64'd0, 66};
    vecs[3]  = '{"div_m7_2",     F3_DIV,    1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66};
    vecs[4]  = '{"rem_m7_2",     F3_REM,    1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66};
    vecs[5]  = '{"divw",         F3_DIV,    1'b1, 64'h1_0000_0010, 64'd4, 64'd4, 34};
    vecs[6]  = '{"divu_zero",    F3_DIVU,   1'b0, 64'h1234, 64'd0, '1, 1};
    vecs[7]  = '{"rem_ovf",      F3_REM,    1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, 1};
    vecs[8]  = '{"div_ovf",      F3_DIV,    1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1};
    vecs[9]  = '{"mulw_wrap",    F3_MUL,    1'b1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 34};
    vecs[10] = '{"remw_zero",    F3_REM,    1'b1, 64'h8000_0001, 64'h1_0000_0000, 64'hFFFF_FFFF_8000_0001, 1};
    vecs[11] = '{"divw_ovf",     F3_DIV,    1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1};
    vecs[12] = '{"mulhsu_m1_2",  F3_MULHSU, 1'b0, '1, 64'd2, '1, 66};

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check64("reset_done", 64'(MDDone_E), 64'd0);
    check64("reset_stall", 64'(Stall_MD), 64'd0);
    check64("reset_result", MDResult_E, 64'd0);
    check64("reset_state", 64'(dut.state_q), 64'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table, issued back to back
    for (int i = 0; i < NVEC; i++)
      run_op(vecs[i].name, vecs[i].f3, vecs[i].w, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat);

    // Flush at cycle 10 of a DIV, then a MUL accepted the following cycle
    MD_Start_E = 1'b1; funct3_E = F3_DIV; is_word_E = 1'b0; SrcA_E = 64'd100; SrcB_E = 64'd7;
    repeat (10) @(negedge clk);
    Flush_E = 1'b1;
    #1;
    check64("flush_stall", 64'(Stall_MD), 64'd0);
    check64("flush_done", 64'(MDDone_E), 64'd0);
    @(negedge clk);
    Flush_E = 1'b0;
    run_op("mul_after_flush", F3_MUL, 1'b0, 64'd5, 64'd6, 64'd30, 66);

    // Start dropped mid-CALC aborts without a done pulse
    MD_Start_E = 1'b1; funct3_E = F3_DIV; is_word_E = 1'b0; SrcA_E = 64'd1000; SrcB_E = 64'd3;
    repeat (5) @(negedge clk);
    MD_Start_E = 1'b0;
    watch_no_done("abort_no_done", 80);
    check64("abort_result_held", MDResult_E, 64'd30);

    // Asynchronous reset at cycle 20 of a MUL
    MD_Start_E = 1'b1; funct3_E = F3_MUL; is_word_E = 1'b0; SrcA_E = 64'd9; SrcB_E = 64'd9;
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    MD_Start_E = 1'b0;
    #1;
    check64("midreset_done", 64'(MDDone_E), 64'd0);
    check64("midreset_stall", 64'(Stall_MD), 64'd0);
    check64("midreset_result", MDResult_E, 64'd0);
    check64("midreset_state", 64'(dut.state_q), 64'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    watch_no_done("postreset_no_done", 80);
    check64("postreset_result", MDResult_E, 64'd0);
    run_op("mul_after_reset", F3_MUL, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD,
           64'hFFFF_FFFF_FFFF_FFEB, 66);

    // Randomized ops against the reference model
    for (int i = 0; i < 60; i++) begin
      w  = ($urandom_range(0, 2) == 0);
      f3 = w ? w_ops[$urandom_range(0, 4)] : 3'($urandom_range(0, 7));
      a  = rand_operand();
      b  = rand_operand();
      run_op("rand", f3, w, a, b, ref_md(f3, w, a, b), ref_lat(f3, w, a, b));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
